// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a MIPS-subset datapath with a
// data-memory req/ack handshake and timeout. Optional counters under PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] OpCode,
  input  logic       Zero,
  input  logic       mem_ack,
  output logic       PC_En,
  output logic       IR_En,
  output logic       BR_En,
  output logic [2:0] AluC,
  output logic       EnW,
  output logic       EnR,
  output logic       Mux1,
  output logic       Mux2,
  output logic       Mux3,
  output logic       Branch,
  output logic       illegal,
  output logic       mem_err,
  output logic       retire,
  output logic [2:0] state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: is_legal = 1'b1;
      default:                             is_legal = 1'b0;
    endcase
  endfunction

  // {AluC, Mux1, Mux2, Mux3} per opcode
  function automatic logic [5:0] op_fields(input logic [5:0] op);
    case (op)
      OP_R:    op_fields = {3'b000, 1'b1, 1'b1, 1'b0};
      OP_ADDI: op_fields = {3'b010, 1'b1, 1'b0, 1'b1};
      OP_LW:   op_fields = {3'b010, 1'b0, 1'b0, 1'b1};
      OP_SW:   op_fields = {3'b010, 1'b1, 1'b1, 1'b1};
      OP_BEQ:  op_fields = {3'b011, 1'b0, 1'b0, 1'b0};
      default: op_fields = 6'b000000;
    endcase
  endfunction

  state_t           r_state;
  state_t           w_next;
  state_t           w_after;
  logic [5:0]       r_op;
  logic [TMO_W-1:0] r_cnt;
  logic             w_timeout;
  logic             w_mem_done;

  // mem_ack on the final allowed cycle still completes the access
  assign w_timeout  = (MEM_TIMEOUT != 0) && (r_state == S_MEM) && (r_cnt == TMO_LIM) && !mem_ack;
  assign w_mem_done = (r_state == S_MEM) && (mem_ack || w_timeout);
  assign w_after    = run ? S_FETCH : S_IDLE;

  // State, latched opcode and MEM wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= 6'b000000;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= OpCode;
      end
      if ((r_state == S_MEM) && !w_mem_done) begin
        if (r_cnt != {TMO_W{1'b1}}) begin
          r_cnt <= r_cnt + TMO_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = run ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = is_legal(OpCode) ? S_EXEC : w_after;
      S_EXEC: begin
        case (r_op)
          OP_R, OP_ADDI: w_next = S_WB;
          OP_LW, OP_SW:  w_next = S_MEM;
          default:       w_next = w_after;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          w_next = (r_op == OP_LW) ? S_WB : w_after;
        end else if (w_timeout) begin
          w_next = w_after;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB:     w_next = w_after;
      default:  w_next = S_IDLE;
    endcase
  end

  // Per-state datapath controls and status pulses
  always_comb begin
    PC_En   = 1'b0;
    IR_En   = 1'b0;
    BR_En   = 1'b0;
    AluC    = 3'b000;
    EnW     = 1'b0;
    EnR     = 1'b0;
    Mux1    = 1'b0;
    Mux2    = 1'b0;
    Mux3    = 1'b0;
    Branch  = 1'b0;
    illegal = 1'b0;
    mem_err = 1'b0;
    retire  = 1'b0;
    state   = r_state;
    if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
      {AluC, Mux1, Mux2, Mux3} = op_fields(r_op);
    end else begin
      {AluC, Mux1, Mux2, Mux3} = 6'b000000;
    end
    case (r_state)
      S_FETCH: begin
        IR_En = 1'b1;
        PC_En = 1'b1;
      end
      S_DECODE: illegal = !is_legal(OpCode);
      S_EXEC: begin
        if (r_op == OP_BEQ) begin
          Branch = 1'b1;
          PC_En  = Zero;
          retire = 1'b1;
        end else begin
          Branch = 1'b0;
        end
      end
      S_MEM: begin
        EnR     = (r_op == OP_LW);
        EnW     = (r_op == OP_SW);
        mem_err = w_timeout;
        retire  = mem_ack && (r_op == OP_SW);
      end
      S_WB: begin
        BR_En  = 1'b1;
        retire = 1'b1;
      end
      default: begin
        PC_En = 1'b0;
      end
    endcase
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_instr_cnt;
  logic [31:0] r_stall_cnt;

  // Retired-instruction and memory-stall counters, free-running with wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (retire) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
      if ((r_state == S_MEM) && !mem_ack) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign instr_cnt = r_instr_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each opcode through its phases and checks
// the full output vector every cycle against hand-computed values.
module tb_multicycle_ctrl;
  logic       clk;
  logic       rst_n;
  logic       run;
  logic [5:0] OpCode;
  logic       Zero;
  logic       mem_ack;
  logic       PC_En, IR_En, BR_En, EnW, EnR, Mux1, Mux2, Mux3, Branch;
  logic       illegal, mem_err, retire;
  logic [2:0] AluC;
  logic [2:0] state;

  int checks;
  int failures;

  multicycle_ctrl #(.MEM_TIMEOUT(15), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .OpCode(OpCode), .Zero(Zero),
    .mem_ack(mem_ack), .PC_En(PC_En), .IR_En(IR_En), .BR_En(BR_En), .AluC(AluC),
    .EnW(EnW), .EnR(EnR), .Mux1(Mux1), .Mux2(Mux2), .Mux3(Mux3), .Branch(Branch),
    .illegal(illegal), .mem_err(mem_err), .retire(retire), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input logic [2:0] st, input logic pc, input logic ir,
                                     input logic brn, input logic [2:0] alu, input logic enw,
                                     input logic enr, input logic m1, input logic m2,
                                     input logic m3, input logic bra, input logic ill,
                                     input logic err, input logic ret);
    return {st, pc, ir, brn, alu, enw, enr, m1, m2, m3, bra, ill, err, ret};
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp);
    logic [17:0] obs;
    obs = {state, PC_En, IR_En, BR_En, AluC, EnW, EnR, Mux1, Mux2, Mux3,
           Branch, illegal, mem_err, retire};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // check the current cycle (inputs already applied), then advance one clock
  task automatic cyc_chk(input string tag, input logic [17:0] exp);
    #1;
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    run      = 1'b0;
    OpCode   = 6'b000000;
    Zero     = 1'b0;
    mem_ack  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 18'd0);
    rst_n = 1'b1;
    cyc_chk("idle_hold", 18'd0);
    run = 1'b1;
    cyc_chk("idle_run", 18'd0);

    // R-type, mem_ack stays 0
    OpCode = 6'b000000;
    cyc_chk("r_fetch",  mk(3'd1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("r_decode", mk(3'd2, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("r_exec",   mk(3'd3, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("r_wb",     mk(3'd5, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

    // LW, ack on the 4th MEM cycle, retire on cycle 8
    OpCode = 6'b100011;
    cyc_chk("lw_fetch",  mk(3'd1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("lw_decode", mk(3'd2, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("lw_exec",   mk(3'd3, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      cyc_chk("lw_mem_wait", mk(3'd4, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    mem_ack = 1'b1;
    cyc_chk("lw_mem_ack", mk(3'd4, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    mem_ack = 1'b0;
    cyc_chk("lw_wb",      mk(3'd5, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));

    // BEQ taken then not taken
    OpCode = 6'b000100;
    cyc_chk("beq1_fetch",  mk(3'd1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("beq1_decode", mk(3'd2, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    Zero = 1'b1;
    cyc_chk("beq1_exec",   mk(3'd3, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    Zero = 1'b0;
    cyc_chk("beq0_fetch",  mk(3'd1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("beq0_decode", mk(3'd2, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("beq0_exec",   mk(3'd3, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));

    // SW timeout: 16 MEM cycles, mem_err on the last
    OpCode = 6'b101011;
    cyc_chk("swt_fetch",  mk(3'd1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("swt_decode", mk(3'd2, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("swt_exec",   mk(3'd3, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 15; i++) begin
      cyc_chk("swt_mem_wait", mk(3'd4, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    cyc_chk("swt_mem_err", mk(3'd4, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));

    // SW with ack on the 16th MEM cycle still retires
    cyc_chk("sw_fetch",  mk(3'd1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("sw_decode", mk(3'd2, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("sw_exec",   mk(3'd3, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 15; i++) begin
      cyc_chk("sw_mem_wait", mk(3'd4, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    mem_ack = 1'b1;
    cyc_chk("sw_mem_ack16", mk(3'd4, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    mem_ack = 1'b0;

    // Illegal opcode returns to FETCH
    OpCode = 6'b111111;
    cyc_chk("ill_fetch",  mk(3'd1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("ill_decode", mk(3'd2, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

    // ADDI with run dropped in EXEC: completes through WB then IDLE
    OpCode = 6'b001000;
    cyc_chk("addi_fetch",  mk(3'd1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("addi_decode", mk(3'd2, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run = 1'b0;
    cyc_chk("addi_exec",   mk(3'd3, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("addi_wb",     mk(3'd5, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc_chk("addi_idle",   18'd0);
    cyc_chk("addi_idle2",  18'd0);

    // Reset asserted during LW MEM
    run = 1'b1;
    OpCode = 6'b100011;
    cyc_chk("rlw_idle",   18'd0);
    cyc_chk("rlw_fetch",  mk(3'd1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("rlw_decode", mk(3'd2, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc_chk("rlw_exec",   mk(3'd3, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    #1;
    chk("rlw_mem", mk(3'd4, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem", 18'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b0;
    cyc_chk("rst_release_idle", 18'd0);
    cyc_chk("rst_idle_hold",    18'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
